// File: rtl/mc6809_pkg.sv
// rtl/mc6809_pkg.sv - shared phase/DMA enums and default parameters for the MC6809 E/Q generator
package mc6809_pkg;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;
  typedef enum logic [1:0] {IDLE, GRANT, REFRESH} dma_state_e;

  localparam int DIV_DEF         = 1;
  localparam int STRETCH_MAX_DEF = 8;
  localparam int DMA_MAX_DEF     = 15;

endpackage

// File: rtl/mc6809_dma_arb.sv
// rtl/mc6809_dma_arb.sv - DMA/bus-request arbiter with grant counter and forced refresh cycle
module mc6809_dma_arb
  import mc6809_pkg::*;
#(
  parameter int DMA_MAX = DMA_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic efall_i,
  input  logic ndmabreq_i,
  output logic gnt_o,
  output logic refresh_o
);

  dma_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (efall_i) begin
      case (state_q)
        IDLE, REFRESH: begin
          if (!ndmabreq_i) begin
            state_d = GRANT;
            cnt_d   = 8'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        GRANT: begin
          // A released request ends the grant cleanly; no refresh is owed
          if (ndmabreq_i) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_q == 8'(DMA_MAX)) begin
            state_d = REFRESH;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  assign gnt_o     = (state_q == GRANT);
  assign refresh_o = (state_q == REFRESH);

endmodule

// File: rtl/mc6809_eq_gen.sv
// rtl/mc6809_eq_gen.sv - MC6809 E/Q quadrature clock generator with MRDY stretch
// Optional DMA arbiter enabled by macro MC6809_DMABREQ_EN.
module mc6809_eq_gen
  import mc6809_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int STRETCH_MAX = STRETCH_MAX_DEF,
  parameter int DMA_MAX     = DMA_MAX_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic MRDY,
  input  logic nDMABREQ,
  output logic E,
  output logic Q,
  output logic E_RISE,
  output logic E_FALL,
  output logic STRETCH,
  output logic DMA_GNT,
  output logic DMA_REFRESH
);

  localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;

  phase_e        phase_q, phase_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [7:0]    scnt_q, scnt_d;
  logic          stretch_q, stretch_d;
  logic          e_q, e_d, q_q, q_d;
  logic          e_rise_q, e_rise_d, e_fall_q, e_fall_d;
  logic          quarter_end;

  assign quarter_end = (qcnt_q == QW'(DIV - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase_q   <= P0;
      qcnt_q    <= '0;
      scnt_q    <= 8'd0;
      stretch_q <= 1'b0;
      e_q       <= 1'b0;
      q_q       <= 1'b0;
      e_rise_q  <= 1'b0;
      e_fall_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      qcnt_q    <= qcnt_d;
      scnt_q    <= scnt_d;
      stretch_q <= stretch_d;
      e_q       <= e_d;
      q_q       <= q_d;
      e_rise_q  <= e_rise_d;
      e_fall_q  <= e_fall_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    qcnt_d    = qcnt_q + 1'b1;
    scnt_d    = scnt_q;
    stretch_d = stretch_q;
    e_rise_d  = 1'b0;
    e_fall_d  = 1'b0;
    if (quarter_end) begin
      qcnt_d = '0;
      case (phase_q)
        P0: phase_d = P1;
        P1: begin
          phase_d  = P2;
          e_rise_d = 1'b1;
        end
        P2: phase_d = P3;
        default: begin
          // MRDY is sampled only at the close of P3 or of a stretch quarter
          if (!MRDY && (scnt_q != 8'(STRETCH_MAX))) begin
            stretch_d = 1'b1;
            scnt_d    = scnt_q + 8'd1;
          end else begin
            phase_d   = P0;
            stretch_d = 1'b0;
            scnt_d    = 8'd0;
            e_fall_d  = 1'b1;
          end
        end
      endcase
    end
    e_d = (phase_d == P2) || (phase_d == P3);
    q_d = (phase_d == P1) || (phase_d == P2);
  end

  assign E       = e_q;
  assign Q       = q_q;
  assign E_RISE  = e_rise_q;
  assign E_FALL  = e_fall_q;
  assign STRETCH = stretch_q;

`ifdef MC6809_DMABREQ_EN
  // Fed with the next-state strobe so the grant moves in the same CLK that E_FALL reads 1
  mc6809_dma_arb #(
    .DMA_MAX(DMA_MAX)
  ) u_dma_arb (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .efall_i   (e_fall_d),
    .ndmabreq_i(nDMABREQ),
    .gnt_o     (DMA_GNT),
    .refresh_o (DMA_REFRESH)
  );
`else
  localparam int unused_dma_max = DMA_MAX;
  logic unused_dmabreq;
  assign unused_dmabreq = nDMABREQ;
  assign DMA_GNT        = 1'b0;
  assign DMA_REFRESH    = 1'b0;
`endif

endmodule

// File: tb/tb_mc6809_eq_gen.sv
// tb/tb_mc6809_eq_gen.sv - randomized self-checking bench for mc6809_eq_gen against a timeline model
module tb_mc6809_eq_gen;

  localparam int DIV  = 2;
  localparam int SMAX = 3;
  localparam int DMAX = 4;
  localparam bit DMA_EN =
`ifdef MC6809_DMABREQ_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mrdy = 1'b1;
  logic nbreq = 1'b1;
  logic e, q, e_rise, e_fall, stretch, dma_gnt, dma_refresh;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  // Model: position t within the current E cycle, extra quarters so far, DMA state (0 idle, 1 grant, 2 refresh)
  int t, ext, dst, dcnt;
  bit fresh;

  mc6809_eq_gen #(.DIV(DIV), .STRETCH_MAX(SMAX), .DMA_MAX(DMAX)) dut (
    .CLK(clk), .RESET(rst), .MRDY(mrdy), .nDMABREQ(nbreq),
    .E(e), .Q(q), .E_RISE(e_rise), .E_FALL(e_fall), .STRETCH(stretch),
    .DMA_GNT(dma_gnt), .DMA_REFRESH(dma_refresh)
  );

  assign obs = {e, q, e_rise, e_fall, stretch, dma_gnt, dma_refresh};

  always #5 clk = ~clk;

  task automatic model_reset();
    t = 0; ext = 0; fresh = 1'b1; dst = 0; dcnt = 0;
  endtask

  function automatic logic [6:0] model_out();
    return {t >= 2*DIV, (t >= DIV) && (t < 3*DIV), t == 2*DIV, (t == 0) && !fresh,
            t >= 4*DIV, DMA_EN && (dst == 1), DMA_EN && (dst == 2)};
  endfunction

  task automatic dma_model(input bit nb);
    bit req;
    req = !nb;
    if (dst == 1) begin
      if (!req) begin dst = 0; dcnt = 0; end
      else if (dcnt == DMAX) begin dst = 2; dcnt = 0; end
      else dcnt = dcnt + 1;
    end else if (req) begin
      dst = 1; dcnt = 1;
    end else begin
      dst = 0; dcnt = 0;
    end
  endtask

  // Drive inputs for the coming edge and advance the model by one CLK
  task automatic drive_step(input bit m, input bit nb);
    mrdy = m;
    nbreq = nb;
    if (t == 4*DIV - 1 + ext*DIV) begin
      if (!m && ext < SMAX) begin
        ext = ext + 1; t = t + 1;
      end else begin
        t = 0; ext = 0; fresh = 1'b0;
        dma_model(nb);
      end
    end else begin
      t = t + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs, 7'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_free_run();
    int rises = 0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL free_run cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      if (e_rise) rises++;
      drive_step(1'b1, 1'b1);
    end
    checks++;
    if (rises !== 5) begin
      errors++;
      $display("FAIL free_run_rises got=%0d exp=5", rises);
    end
  endtask

  task automatic test_stretch_random();
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL stretch_random cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      drive_step($urandom_range(0, 2) != 0, 1'b1);
    end
  endtask

  task automatic test_stretch_max();
    int hi = 0;
    bit armed = 1'b0;
    for (int i = 0; i < 80; i++) begin
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL stretch_max cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      if (e_rise) begin
        armed = 1'b1; hi = 1;
      end else if (armed && e) begin
        hi++;
      end else if (armed && hi > 0) begin
        checks++;
        if (hi !== (2 + SMAX) * DIV) begin
          errors++;
          $display("FAIL stretch_max_ehigh got=%0d exp=%0d", hi, (2 + SMAX) * DIV);
        end
        hi = 0;
      end
      drive_step(1'b0, 1'b1);
    end
  endtask

  task automatic test_dma_hold();
    for (int i = 0; i < 300; i++) begin
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL dma_hold cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      checks++;
      if (dma_gnt && dma_refresh) begin
        errors++;
        $display("FAIL dma_exclusive cyc=%0d got=11 exp=not both", i);
      end
      drive_step($urandom_range(0, 3) != 0, 1'b0);
    end
  endtask

  task automatic test_dma_release();
    bit nb = 1'b0;
    for (int i = 0; i < 500; i++) begin
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL dma_release cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      if ($urandom_range(0, 24) == 0) nb = !nb;
      drive_step($urandom_range(0, 3) != 0, nb);
    end
  endtask

  task automatic test_reset_mid();
    int wait_cyc = 0;
    int rise_at = -1;
    while (!(ext > 0 && (dst == 1 || !DMA_EN)) && wait_cyc < 200) begin
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", wait_cyc, obs, model_out());
      end
      drive_step(1'b0, 1'b0);
      wait_cyc++;
    end
    checks++;
    if (wait_cyc >= 200) begin
      errors++;
      $display("FAIL reset_mid_setup got=timeout exp=stretch with grant");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", obs, 7'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, 7'b0);
      end
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      if (e_rise && rise_at < 0) rise_at = i;
      drive_step(1'b1, 1'b1);
    end
    checks++;
    if (rise_at !== 2*DIV) begin
      errors++;
      $display("FAIL reset_first_rise got=%0d exp=%0d", rise_at, 2*DIV);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_stretch_random();
    test_stretch_max();
    test_dma_hold();
    test_dma_release();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc6809_eq_gen.md
MC6809_EQ_GEN -- requirements
Module: mc6809_eq_gen

Interface
REQ-001 Parameter DIV, default 1: CLK cycles per quarter phase; range 1..64.
REQ-002 Parameter STRETCH_MAX, default 8: maximum extra quarter phases per MRDY stretch; range 1..255.
REQ-003 Parameter DMA_MAX, default 15: granted E cycles before a forced refresh cycle; range 1..255.
REQ-004 CLK  in  1  sole clock; all state on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 MRDY  in  1  memory ready; low requests E stretch.
REQ-007 nDMABREQ  in  1  active-low DMA/bus request.
REQ-008 E  out  1  bus clock.
REQ-009 Q  out  1  quadrature clock, leads E by one quarter.
REQ-010 E_RISE  out  1  one-CLK enable, high in the first CLK where E reads 1.
REQ-011 E_FALL  out  1  one-CLK enable, high in the first CLK where E reads 0.
REQ-012 STRETCH  out  1  high while a stretch quarter is in progress.
REQ-013 DMA_GNT  out  1  bus granted to DMA for the current E cycle.
REQ-014 DMA_REFRESH  out  1  high for the whole forced refresh E cycle.

Function
REQ-015 Quarter counter counts 0..DIV-1; phase advances when it reaches DIV-1.
REQ-016 Phase sequence P0(E=0,Q=0) -> P1(E=0,Q=1) -> P2(E=1,Q=1) -> P3(E=1,Q=0) -> P0.
REQ-017 Unstretched E period is exactly 4*DIV CLK cycles, 50% duty; E and Q registered, glitch-free.
REQ-018 MRDY is sampled in the last CLK of P3 and of each stretch quarter.
REQ-019 MRDY low at that sample adds one further P3 quarter (E=1, Q=0, STRETCH=1), and the stretch counter increments.
REQ-020 When the stretch counter reaches STRETCH_MAX, the next transition goes to P0 regardless of MRDY; the counter clears at P0.
REQ-021 MRDY high at the sample ends the stretch: next quarter is P0.
REQ-022 DMA logic evaluates only in the E_FALL cycle, and its outputs change in that cycle.
REQ-023 Idle: nDMABREQ low at E_FALL -> DMA_GNT=1 for the following E cycle; grant counter = 1.
REQ-024 Granted: nDMABREQ low and grant counter < DMA_MAX -> stay granted; counter increments.
REQ-025 Granted: grant counter = DMA_MAX -> DMA_GNT=0 and DMA_REFRESH=1 for exactly one E cycle; counter clears.
REQ-026 Refresh: at the next E_FALL, nDMABREQ low -> regrant (counter = 1); high -> idle.
REQ-027 Granted: nDMABREQ high at E_FALL -> DMA_GNT=0, idle, counter clears; no refresh cycle.
REQ-028 DMA_GNT and DMA_REFRESH are never high together.
REQ-029 Stretching does not count as an E cycle for the grant counter.

Reset
REQ-030 RESET high immediately forces P0, all counters 0, E=Q=0, E_RISE=E_FALL=0, STRETCH=0, DMA_GNT=0, DMA_REFRESH=0.
REQ-031 RESET mid-stretch or mid-grant aborts the operation without any further pulse.
REQ-032 After RESET deasserts, the first E_RISE occurs 2*DIV CLK cycles later.

Configuration
REQ-033 Macro MC6809_DMABREQ_EN defined: DMA arbiter per REQ-022..029.
REQ-034 Macro MC6809_DMABREQ_EN undefined: nDMABREQ is ignored, DMA_GNT=0 and DMA_REFRESH=0 constantly, and no grant counter is built.

Structure
REQ-035 Shared package mc6809_pkg holds the phase enum (P0..P3), DMA state enum (IDLE, GRANT, REFRESH) and default parameter constants.
REQ-036 Sub-module mc6809_dma_arb holds the DMA state machine and grant counter; it is driven by E_FALL and nDMABREQ and instantiated only under MC6809_DMABREQ_EN.

Verification
REQ-037 DIV=1, MRDY=1 -> E period 4 CLK, Q rises 1 CLK before E, one E_RISE and one E_FALL per period.
REQ-038 DIV=2, MRDY low for 3 samples -> E high for 4+6=10 CLK with STRETCH=1 for 6 CLK.
REQ-039 MRDY held low, STRETCH_MAX=8, DIV=1 -> E high exactly 2+8=10 CLK, then normal.
REQ-040 nDMABREQ held low, DMA_MAX=15 -> 15 E cycles DMA_GNT=1, 1 cycle DMA_REFRESH=1, then regrant; repeats.
REQ-041 nDMABREQ released after 5 granted cycles -> DMA_GNT falls at the next E_FALL with no refresh.
REQ-042 RESET pulse mid-stretch with DMA granted -> all outputs 0 at once; first E_RISE 2*DIV CLK after release.
